// File: rtl/eq_serial_pkg.sv
// Shared types for the serial equality comparator: FSM state encoding and the
// width helper used to size the mismatch index.
package eq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for a W-bit operand; W >= 2 keeps this at least 1.
    function automatic int idx_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/eq_serial_if.sv
// Request/result bundle of eq_serial. The master issues start with operands.
// The slave returns ready, done_tick and the registered result.
interface eq_serial_if #(
    parameter int W = 8
) ();
    import eq_pkg::*;

    localparam int IW = idx_w(W);

    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ready;
    logic          done_tick;
    logic          eq;
    logic [IW-1:0] mismatch_idx;

    modport master (
        output start, a, b,
        input  ready, done_tick, eq, mismatch_idx
    );

    modport slave (
        input  start, a, b,
        output ready, done_tick, eq, mismatch_idx
    );

endinterface

// File: rtl/eq_serial_eq1_cell.sv
// purpose: 1-bit equality (XNOR) cell
// latency: combinational
// backpressure: none
module eq1_cell (
    input  logic x,
    input  logic y,
    output logic eq
);

    assign eq = ~(x ^ y);

endmodule

// File: rtl/eq_serial.sv
// purpose: serial a==b compare, LSB first, one bit per clock through a single eq1_cell
// latency: W+1 cycles on full match, k+2 cycles on first mismatch at bit k
// backpressure: ready low while busy; start is ignored until ready returns
module eq_serial
    import eq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       reset,
    eq_serial_if.slave bus
);

    localparam int            IW     = idx_w(W);
    // Terminal index is compared directly, so no reliance on n wrapping.
    localparam logic [IW-1:0] N_LAST = IW'(W - 1);

    state_t        state;
    state_t        state_nxt;

    logic [W-1:0]  sa;
    logic [W-1:0]  sb;
    logic [IW-1:0] n;
    logic          bit_eq;

    logic          load;
    logic          shift;
    logic          wr_res;
    logic          ready_c;
    logic          done_c;

    logic          eq_q;
    logic [IW-1:0] idx_q;

    eq1_cell u_cell (
        .x  (sa[0]),
        .y  (sb[0]),
        .eq (bit_eq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        wr_res    = 1'b0;
        ready_c   = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = CMP;
                end
            end
            CMP: begin
                if (!bit_eq || (n == N_LAST)) begin
                    wr_res    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    shift = 1'b1;
                end
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sa    <= '0;
            sb    <= '0;
            n     <= '0;
            eq_q  <= 1'b0;
            idx_q <= '0;
        end else begin
            if (load) begin
                sa <= bus.a;
                sb <= bus.b;
                n  <= '0;
            end else if (shift) begin
                sa <= sa >> 1;
                sb <= sb >> 1;
                n  <= n + IW'(1);
            end
            // Result registers only move on the exit from CMP.
            if (wr_res) begin
                eq_q  <= bit_eq;
                idx_q <= bit_eq ? '0 : n;
            end
        end
    end

    assign bus.ready        = ready_c;
    assign bus.done_tick    = done_c;
    assign bus.eq           = eq_q;
    assign bus.mismatch_idx = idx_q;

endmodule

// File: tb/tb_eq_serial.sv
// Bench for eq_serial: vector table plus hand sequences for ignored starts,
// mid-compare reset and back-to-back starts, checked through a result scoreboard.
module tb_eq_serial;
    import eq_pkg::*;

    localparam int W  = 8;
    localparam int IW = idx_w(W);

    logic clk = 1'b0;
    logic reset;

    eq_serial_if #(.W(W)) bus ();

    eq_serial #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          eq;
        logic [IW-1:0] idx;
        int            start_cyc;
        int            lat;
    } exp_t;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          e_eq;
        logic [IW-1:0] e_idx;
        int            e_lat;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[10];

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;
    bit mon_en = 1'b0;
    bit chk_rdy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Result monitor: every done_tick must match the oldest outstanding request.
    always @(negedge clk) begin
        if (mon_en) begin
            if (chk_rdy) begin
                chk("ready_after_done", int'(bus.ready), 1);
                chk_rdy = 1'b0;
            end
            if (bus.done_tick === 1'b1) begin
                n_done++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("eq", int'(bus.eq), int'(mon_e.eq));
                    chk("mismatch_idx", int'(bus.mismatch_idx), int'(mon_e.idx));
                    chk("latency", cyc - mon_e.start_cyc, mon_e.lat);
                    chk("ready_in_done", int'(bus.ready), 0);
                    chk_rdy = 1'b1;
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (bus.ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (bus.ready !== 1'b1) chk("ready_timeout", 0, 1);
    endtask

    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic e_eq, input logic [IW-1:0] e_idx, input int e_lat);
        wait_ready();
        bus.a     = va;
        bus.b     = vb;
        bus.start = 1'b1;
        sb_q.push_back('{eq: e_eq, idx: e_idx, start_cyc: cyc, lat: e_lat});
        tick();
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 40) begin
            tick();
            t++;
        end
        if (sb_q.size() != 0) begin
            chk("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int n0;
        int t;

        vecs[0] = '{8'hA5, 8'hA5, 1'b1, 3'd0, 9};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 3'd0, 2};
        vecs[2] = '{8'h80, 8'h00, 1'b0, 3'd7, 9};
        vecs[3] = '{8'h10, 8'h00, 1'b0, 3'd4, 6};
        vecs[4] = '{8'hFF, 8'hFE, 1'b0, 3'd0, 2};
        vecs[5] = '{8'h55, 8'h57, 1'b0, 3'd1, 3};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 3'd0, 9};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 3'd0, 9};
        vecs[8] = '{8'hC3, 8'h43, 1'b0, 3'd7, 9};
        vecs[9] = '{8'h0F, 8'h2F, 1'b0, 3'd5, 7};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_done_tick", int'(bus.done_tick), 0);
        chk("rst_eq", int'(bus.eq), 0);
        chk("rst_idx", int'(bus.mismatch_idx), 0);
        mon_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].e_eq, vecs[i].e_idx, vecs[i].e_lat);
            drain();
        end

        // Starts and operand changes while busy must be ignored.
        wait_ready();
        bus.a     = 8'h3C;
        bus.b     = 8'h3C;
        bus.start = 1'b1;
        sb_q.push_back('{eq: 1'b1, idx: '0, start_cyc: cyc, lat: 9});
        n0 = n_done;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            bus.start = 1'b1;
            if (c == 2) begin
                bus.a = 8'h00;
                bus.b = 8'hFF;
            end
            tick();
        end
        bus.start = 1'b0;
        drain();
        repeat (12) tick();
        chk("single_done", n_done - n0, 1);

        // Reset in cycle 3 abandons the compare and clears the result.
        wait_ready();
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_ready", int'(bus.ready), 1);
        chk("midrst_eq", int'(bus.eq), 0);
        chk("midrst_idx", int'(bus.mismatch_idx), 0);
        chk("midrst_done_tick", int'(bus.done_tick), 0);
        n0 = n_done;
        repeat (12) tick();
        chk("no_done_after_reset", n_done - n0, 0);

        // start held high: equal pair, then a pair differing at bit 2.
        wait_ready();
        bus.a     = 8'hA5;
        bus.b     = 8'hA5;
        bus.start = 1'b1;
        c0 = cyc;
        sb_q.push_back('{eq: 1'b1, idx: '0, start_cyc: cyc, lat: 9});
        tick();
        bus.a = 8'h00;
        bus.b = 8'h04;
        t = 0;
        while (bus.ready !== 1'b1 && t < 30) begin
            tick();
            t++;
        end
        chk("turnaround", cyc - c0, 10);
        sb_q.push_back('{eq: 1'b0, idx: 3'd2, start_cyc: cyc, lat: 4});
        tick();
        bus.start = 1'b0;
        drain();
        repeat (3) tick();
        chk("hold_eq", int'(bus.eq), 0);
        chk("hold_idx", int'(bus.mismatch_idx), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eq_serial.md
# eq_serial

Sequential word equality comparator. It loads two W-bit operands on a start request and compares them one bit per clock, LSB first, using a single 1-bit equality cell. It stops at the first mismatching bit and reports equality plus the index of that bit. It sits beside the combinational comparators in the chapter-1 library as their area-minimal, multi-cycle counterpart, for checkers and test benches that compare words arriving at low rate.

## Interface
- W, default 8: operand width in bits; W >= 2.
- clk  input  1: clock; all state changes on the rising edge.
- reset  input  1: synchronous, active-high reset.
- start  input  1: compare request; sampled only when ready=1.
- a  input  W: operand A; captured on an accepted start.
- b  input  W: operand B; captured on an accepted start.
- ready  output  1: high in idle; block accepts start.
- done_tick  output  1: one-cycle pulse; result valid.
- eq  output  1: 1 when the last compare found a==b; registered.
- mismatch_idx  output  IW: index of the first differing bit; 0 when eq=1. IW = $clog2(W).

## Operation
- States:
  - idle: ready=1. start=1 latches a, b into shift registers sa, sb, clears bit counter n to 0, then goes to cmp.
  - cmp: each cycle compares sa[0] with sb[0] through the 1-bit equality cell.
    - Mismatch: eq<=0, mismatch_idx<=n, go to done.
    - Match with n==W-1: eq<=1, mismatch_idx<=0, go to done.
    - Match otherwise: shift sa and sb right by 1, n<=n+1, stay in cmp.
  - done: done_tick=1 for exactly one cycle; ready=0; go to idle.
- start is ignored in cmp and done. Changes on a and b after capture have no effect.
- eq and mismatch_idx hold their values until the next compare writes them. They are updated only on the exit transition from cmp.
- n is IW bits wide. It never exceeds W-1, so no wrap occurs. When W is a power of 2, the W-1 terminal test must not depend on overflow.
- Reset, including mid-compare: state=idle, ready=1, done_tick=0, eq=0, mismatch_idx=0, n=0, sa=sb=0. A compare in progress is abandoned and no done_tick is issued.

## Timing
- Cycle 0 is the edge at which start is sampled with ready=1.
- Bit k is compared in cycle k+1.
- Full match: done_tick is high in cycle W+1. Latency is W+1 cycles.
- First mismatch at bit k: done_tick is high in cycle k+2.
- eq and mismatch_idx are valid from the done_tick cycle onward.
- ready returns high the cycle after done_tick. A start held high continuously is accepted in that cycle, so the turnaround is one idle cycle.
- Minimum start-to-start spacing: k+3 cycles on a mismatch at bit k, W+2 cycles on a full match.

## Structure
- Shared package eq_pkg:
  - state enum {IDLE, CMP, DONE}.
  - Width helper for IW.
- Sub-module eq1_cell: 2-input, 1-output XNOR bit equality. It is instantiated once; the rest of the block is the FSM and datapath.

## Test plan
- W=8, a=b=8'hA5, start at cycle 0 -> done_tick in cycle 9, eq=1, mismatch_idx=0, ready=1 in cycle 10.
- a=8'h00, b=8'h01 -> done_tick in cycle 2, eq=0, mismatch_idx=0.
- a=8'h80, b=8'h00 -> done_tick in cycle 9, eq=0, mismatch_idx=7. a=8'h10, b=8'h00 -> done_tick in cycle 6, mismatch_idx=4.
- Start pulsed again in cycles 1-4, and a/b changed in cycle 2, during an a=b=8'h3C compare -> single done_tick in cycle 9, eq=1, no second compare.
- reset asserted in cycle 3 of an 8'hFF vs 8'hFF compare -> in cycle 4, ready=1, eq=0, mismatch_idx=0; no done_tick within the next 12 cycles.
- start held at 1 with alternating operand pairs (equal, then differing at bit 2) -> done_tick in cycles 9 and 14; eq=1 then 0; mismatch_idx=2 on the second result.
